soc_pll_seq: RTL and testbench

SOC_PLL_SEQ -- requirements
Module: soc_pll_seq

---
 rtl/soc_pll_pkg.sv | 25 ++
 rtl/soc_sync2.sv | 21 ++
 rtl/soc_pll_seq.sv | 129 ++++++++++++
 tb/tb_soc_pll_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/soc_pll_pkg.sv
// Shared types and defaults for the PLL lock sequencer.
package soc_pll_pkg;

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } pll_state_t;

    localparam int DEF_RST_CYCLES   = 250;
    localparam int DEF_LOCK_TIMEOUT = 25000;
    localparam int DEF_LOCK_STABLE  = 1024;
    localparam int DEF_MAX_RETRIES  = 3;

    localparam int ATTEMPT_W = 4;
    localparam int LOSS_W    = 8;

    // Counters run 0..n-1, so $clog2(n) bits suffice; keep at least one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/soc_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
module soc_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/soc_pll_seq.sv
// PLL reset/lock sequencer with retry, lock-stability filter and loss counting.
//   state     | meaning
//   PLL_RST   | PLL held in reset for RST_CYCLES
//   WAIT_LOCK | waiting for lock, bounded by LOCK_TIMEOUT
//   STABLE    | lock must persist LOCK_STABLE cycles
//   RUN       | system released, ready
//   FAIL      | retries exhausted, waiting for force_relock
module soc_pll_seq
    import soc_pll_pkg::*;
#(
    parameter int RST_CYCLES   = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
    parameter int MAX_RETRIES  = DEF_MAX_RETRIES
) (
    input  logic                 refclk,
    input  logic                 rst,
    input  logic                 pll_locked,
    input  logic                 force_relock,
    output logic                 pll_rst,
    output logic                 sys_rst,
    output logic                 ready,
    output logic                 fail,
    output logic [ATTEMPT_W-1:0] attempt,
    output logic [LOSS_W-1:0]    loss_cnt
);

    localparam int RST_W = cnt_width(RST_CYCLES);
    localparam int TO_W  = cnt_width(LOCK_TIMEOUT);
    localparam int STB_W = cnt_width(LOCK_STABLE);

    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE - 1);

    logic                 lk;
    pll_state_t           state, state_nxt;
    logic [RST_W-1:0]     rst_cnt;
    logic [TO_W-1:0]      to_cnt;
    logic [STB_W-1:0]     stb_cnt;
    logic [ATTEMPT_W-1:0] attempt_nxt;
    logic                 loss_inc;
    logic                 in_lock_wait, nxt_lock_wait;

    soc_sync2 u_sync_lock (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lk)
    );

    always_comb begin
        state_nxt   = state;
        attempt_nxt = attempt;
        loss_inc    = 1'b0;
        if (force_relock) begin
            state_nxt   = S_PLL_RST;
            attempt_nxt = ATTEMPT_W'(1);
        end else begin
            case (state)
                S_PLL_RST:   if (rst_cnt == RST_LAST) state_nxt = S_WAIT_LOCK;
                S_WAIT_LOCK: begin
                    if (lk) begin
                        state_nxt = S_STABLE;
                    end else if (to_cnt == TO_LAST) begin
                        if (attempt < ATTEMPT_W'(MAX_RETRIES)) begin
                            attempt_nxt = attempt + ATTEMPT_W'(1);
                            state_nxt   = S_PLL_RST;
                        end else begin
                            state_nxt = S_FAIL;
                        end
                    end
                end
                S_STABLE: begin
                    if (!lk)                      state_nxt = S_WAIT_LOCK;
                    else if (stb_cnt == STB_LAST) state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (!lk) begin
                        loss_inc    = 1'b1;
                        attempt_nxt = ATTEMPT_W'(1);
                        state_nxt   = S_PLL_RST;
                    end
                end
                S_FAIL:  state_nxt = S_FAIL;
                default: state_nxt = S_PLL_RST;
            endcase
        end
    end

    // The timeout budget spans WAIT_LOCK and STABLE so a flapping lock cannot extend it.
    assign in_lock_wait  = (state == S_WAIT_LOCK) || (state == S_STABLE);
    assign nxt_lock_wait = (state_nxt == S_WAIT_LOCK) || (state_nxt == S_STABLE);

    always_ff @(posedge refclk) begin
        if (rst) begin
            state    <= S_PLL_RST;
            attempt  <= ATTEMPT_W'(1);
            loss_cnt <= '0;
            rst_cnt  <= '0;
            to_cnt   <= '0;
            stb_cnt  <= '0;
            pll_rst  <= 1'b1;
            sys_rst  <= 1'b1;
            ready    <= 1'b0;
            fail     <= 1'b0;
        end else begin
            state   <= state_nxt;
            attempt <= attempt_nxt;
            if (loss_inc && (loss_cnt != '1)) loss_cnt <= loss_cnt + LOSS_W'(1);

            rst_cnt <= (state == S_PLL_RST && state_nxt == S_PLL_RST && !force_relock)
                       ? rst_cnt + RST_W'(1) : '0;
            stb_cnt <= (state == S_STABLE && state_nxt == S_STABLE)
                       ? stb_cnt + STB_W'(1) : '0;
            if (in_lock_wait && nxt_lock_wait && !force_relock)
                to_cnt <= (to_cnt == TO_LAST) ? to_cnt : to_cnt + TO_W'(1);
            else
                to_cnt <= '0;

            // Outputs decode the next state so they line up with the state register.
            pll_rst <= (state_nxt == S_PLL_RST) || (state_nxt == S_FAIL);
            sys_rst <= (state_nxt != S_RUN);
            ready   <= (state_nxt == S_RUN);
            fail    <= (state_nxt == S_FAIL);
        end
    end

endmodule

// File: tb/tb_soc_pll_seq.sv
// Directed bench for soc_pll_seq with short sequencing parameters.
module tb_soc_pll_seq;
    import soc_pll_pkg::*;

    logic       refclk = 1'b0;
    logic       rst, pll_locked, force_relock;
    logic       pll_rst, sys_rst, ready, fail;
    logic [3:0] attempt;
    logic [7:0] loss_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    soc_pll_seq #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (20),
        .LOCK_STABLE  (8),
        .MAX_RETRIES  (3)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .force_relock (force_relock),
        .pll_rst      (pll_rst),
        .sys_rst      (sys_rst),
        .ready        (ready),
        .fail         (fail),
        .attempt      (attempt),
        .loss_cnt     (loss_cnt)
    );

    always #5 refclk = ~refclk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    // Samples (current one included) for which pll_rst holds at level.
    task automatic run_len(input logic level, input int limit, output int n);
        n = 0;
        while (pll_rst === level && n < limit) begin
            n++;
            step();
        end
    endtask

    task automatic wait_sys(input logic level, input int limit, output int n);
        n = 0;
        while (sys_rst !== level && n < limit) begin
            step();
            n++;
        end
    endtask

    task automatic wait_ready(input int limit, output int n);
        n = 0;
        while (ready !== 1'b1 && n < limit) begin
            step();
            n++;
        end
    endtask

    // Latencies below count the edge that first captures pll_locked, then the
    // second sync flop, then the FSM reaction edge.
    initial begin
        int n, n2, bad, cnt;
        rst = 1'b1; pll_locked = 1'b0; force_relock = 1'b0;
        step(); step();
        chk("rst_pll_rst", pll_rst, 1);
        chk("rst_sys_rst", sys_rst, 1);
        chk("rst_ready", ready, 0);
        chk("rst_fail", fail, 0);
        chk("rst_attempt", attempt, 1);
        chk("rst_loss", loss_cnt, 0);
        rst = 1'b0;

        // nominal lock
        run_len(1'b1, 50, n);
        chk("nom_pll_rst_len", n, 4);
        repeat (5) step();
        pll_locked = 1'b1;
        wait_sys(1'b0, 100, n);
        chk("nom_sys_rst_lat", n, 1 + 2 + 8);
        chk("nom_ready", ready, 1);
        chk("nom_attempt", attempt, 1);
        chk("nom_pll_rst", pll_rst, 0);

        // lock loss in RUN
        pll_locked = 1'b0;
        wait_sys(1'b1, 20, n);
        chk("loss_lat", n, 1 + 2);
        chk("loss_cnt1", loss_cnt, 1);
        chk("loss_attempt", attempt, 1);
        chk("loss_ready", ready, 0);
        pll_locked = 1'b1;
        wait_ready(100, n);
        chk("loss_relock", ready, 1);

        // force_relock on the very edge the loss would be taken
        pll_locked = 1'b0;
        step(); step();
        force_relock = 1'b1;
        step();
        force_relock = 1'b0;
        chk("fl_loss", loss_cnt, 1);
        chk("fl_pll_rst", pll_rst, 1);
        chk("fl_sys_rst", sys_rst, 1);
        chk("fl_attempt", attempt, 1);
        pll_locked = 1'b1;
        wait_ready(100, n);
        chk("fl_relock", ready, 1);

        // repeated losses until saturation
        bad = 0;
        for (int k = 2; k <= 300; k++) begin
            pll_locked = 1'b0;
            wait_sys(1'b1, 20, n);
            pll_locked = 1'b1;
            wait_ready(100, n2);
            if (n >= 20 || n2 >= 100) bad++;
            if (k == 128 || k == 256) chk("sat_mid", loss_cnt, (k > 255) ? 255 : k);
        end
        chk("sat_timeouts", bad, 0);
        chk("sat_loss", loss_cnt, 255);

        // rst while in STABLE
        pll_locked = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        run_len(1'b1, 50, n);
        pll_locked = 1'b1;
        step(); step(); step();
        chk("rs_in_stable", dut.state, S_STABLE);
        rst = 1'b1;
        step();
        chk("rs_state", dut.state, S_PLL_RST);
        chk("rs_pll_rst", pll_rst, 1);
        chk("rs_sys_rst", sys_rst, 1);
        chk("rs_ready", ready, 0);
        chk("rs_fail", fail, 0);
        chk("rs_attempt", attempt, 1);
        chk("rs_loss", loss_cnt, 0);
        rst = 1'b0;
        step();
        chk("rs_after_pll_rst", pll_rst, 1);
        chk("rs_after_sys_rst", sys_rst, 1);

        // glitchy lock
        pll_locked = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        run_len(1'b1, 50, n);
        pll_locked = 1'b1;
        step(); step(); step();
        chk("gl_stable", dut.state, S_STABLE);
        pll_locked = 1'b0;
        step(); step();
        pll_locked = 1'b1;
        step();
        chk("gl_back_wait", dut.state, S_WAIT_LOCK);
        chk("gl_sys_rst", sys_rst, 1);
        wait_ready(100, n);
        chk("gl_ready_lat", n + 1, 1 + 2 + 8);
        chk("gl_attempt", attempt, 1);
        chk("gl_pll_rst", pll_rst, 0);

        // no lock: three attempts then FAIL
        pll_locked = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        for (int p = 1; p <= 3; p++) begin
            chk("nl_attempt", attempt, p);
            run_len(1'b1, 50, n);
            chk("nl_pll_rst_len", n, 4);
            run_len(1'b0, 50, n);
            chk("nl_wait_len", n, 20);
        end
        chk("nl_fail", fail, 1);
        chk("nl_fail_attempt", attempt, 3);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (fail === 1'b1 && pll_rst === 1'b1 && ready === 1'b0) cnt++;
            step();
        end
        chk("nl_fail_hold", cnt, 100);

        // force_relock out of FAIL
        force_relock = 1'b1;
        step();
        force_relock = 1'b0;
        chk("fr_fail", fail, 0);
        chk("fr_attempt", attempt, 1);
        run_len(1'b1, 50, n);
        chk("fr_pll_rst_len", n, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
